kbd_if: RTL and testbench



---
 rtl/kbd_pkg.sv | 31 +++
 rtl/kbd_debounce.sv | 67 ++++++
 rtl/kbd_if.sv | 167 ++++++++++++++++
 tb/tb_kbd_if.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and types for the keyboard input conditioner.
// The optional FIFO build is selected with the KBD_FIFO_EN macro (see kbd_if).
package kbd_pkg;

    // Width of a key code as presented on the pads and to the CPU.
    localparam int KBD_W = 8;

    // Default number of consecutive synced mismatching cycles before the
    // filtered strobe level flips.
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Default debounce counter width; 2**CNT_W must exceed DEBOUNCE_CYCLES.
    localparam int CNT_W_DEF = 5;

    // Default FIFO depth for the KBD_FIFO_EN build (power of two, >= 2).
    localparam int FIFO_DEPTH_DEF = 4;

    // One captured key code.
    typedef logic [KBD_W-1:0] key_code_t;

    // Number of pointer bits needed to index a FIFO of the given depth.
    function automatic int fifo_ptr_w(input int depth);
        int w;
        w = 1;
        while ((32'sd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : kbd_pkg

// File: rtl/kbd_debounce.sv
// kbd_debounce: two-flop synchroniser plus counter-based debounce filter for
// the raw key strobe. The filtered level only flips after DEBOUNCE_CYCLES
// consecutive synced samples disagree with it; any agreeing sample restarts
// the count. 'rise' pulses for one cycle, combinationally, on the same clock
// edge that the filtered level flips 0->1 so the caller can capture the data
// on that very edge.
module kbd_debounce
    import kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic stb_in,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             stb_s1_r;
    logic             stb_s2_r;
    logic             filt_r;
    logic [CNT_W-1:0] cnt_r;

    logic             mismatch_s;
    logic             at_last_s;
    logic             filt_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Synchroniser, filtered level and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_s1_r <= 1'b0;
            stb_s2_r <= 1'b0;
            filt_r   <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            stb_s1_r <= stb_in;
            stb_s2_r <= stb_s1_r;
            filt_r   <= filt_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Debounce decision: restart on agreement, flip after the full window.
    always_comb begin
        mismatch_s = stb_s2_r ^ filt_r;
        at_last_s  = (cnt_r == CNT_LAST);
        filt_nxt_s = filt_r;
        cnt_nxt_s  = cnt_r;
        if (!mismatch_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (at_last_s) begin
            filt_nxt_s = stb_s2_r;
            cnt_nxt_s  = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Rising flip of the filtered level; only 0->1 is reported.
    assign rise = mismatch_s & at_last_s & stb_s2_r;

endmodule : kbd_debounce

// File: rtl/kbd_if.sv
// kbd_if: keyboard input conditioner in front of the CPU keyboard/en_inp
// inputs. Synchronises the raw key code, debounces the strobe and captures
// one code per clean strobe rising edge. The code is held (with en_inp) until
// the CPU acks; lost captures set a sticky overrun flag cleared by ovr_clr.
// Build option: define KBD_FIFO_EN to replace the single holding register
// with a FIFO_DEPTH-entry circular FIFO.
module kbd_if
    import kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KBD_W-1:0] key_in,
    input  logic             key_stb_in,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic [KBD_W-1:0] keyboard,
    output logic             en_inp,
    output logic             overrun
);

    key_code_t key_s1_r;
    key_code_t key_s2_r;
    logic      capture_s;
    logic      ovr_set_s;
    logic      ovr_r;

    kbd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .stb_in (key_stb_in),
        .rise   (capture_s)
    );

    // Two-flop synchroniser for the key code pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_r <= {KBD_W{1'b0}};
            key_s2_r <= {KBD_W{1'b0}};
        end else begin
            key_s1_r <= key_in;
            key_s2_r <= key_s1_r;
        end
    end

    // Sticky overrun: a new drop takes priority over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_r <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign overrun = ovr_r;

`ifdef KBD_FIFO_EN

    localparam int               PTR_W   = fifo_ptr_w(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    key_code_t        mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   wr_ptr_nxt_s;
    logic [PTR_W:0]   rd_ptr_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    // Push/pop arbitration; a pop frees room for a same-edge push when full.
    always_comb begin
        empty_s      = (wr_ptr_r == rd_ptr_r);
        full_s       = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        pop_s        = ack & ~empty_s;
        push_s       = capture_s & (~full_s | pop_s);
        ovr_set_s    = capture_s & full_s & ~pop_s;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {KBD_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= key_s2_r;
            end
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    assign keyboard = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign en_inp   = ~empty_s;

`else

    key_code_t keyboard_r;
    key_code_t keyboard_nxt_s;
    logic      en_r;
    logic      en_nxt_s;

    // Holding-register update: load when free or acked, otherwise drop.
    always_comb begin
        keyboard_nxt_s = keyboard_r;
        en_nxt_s       = en_r;
        ovr_set_s      = 1'b0;
        if (capture_s) begin
            if (!en_r || ack) begin
                keyboard_nxt_s = key_s2_r;
                en_nxt_s       = 1'b1;
            end else begin
                ovr_set_s      = 1'b1;
            end
        end else if (ack) begin
            en_nxt_s = 1'b0;
        end else begin
            en_nxt_s = en_r;
        end
    end

    // Holding register and valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            keyboard_r <= {KBD_W{1'b0}};
            en_r       <= 1'b0;
        end else begin
            keyboard_r <= keyboard_nxt_s;
            en_r       <= en_nxt_s;
        end
    end

    assign keyboard = keyboard_r;
    assign en_inp   = en_r;

`endif

endmodule : kbd_if

// File: tb/tb_kbd_if.sv
// tb_kbd_if: self-checking bench for kbd_if (DEBOUNCE_CYCLES=4). A queue-based
// reference model tracks the synced strobe history, the captured codes and the
// overrun flag; directed scenarios are followed by a randomized run.
`timescale 1ns/1ps
module tb_kbd_if;

    localparam int DC = 4;
`ifdef KBD_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = 8'h00;
    logic       key_stb_in = 1'b0;
    logic       ack = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] keyboard;
    logic       en_inp;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    kbd_if #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_stb_in (key_stb_in),
        .ack        (ack),
        .ovr_clr    (ovr_clr),
        .keyboard   (keyboard),
        .en_inp     (en_inp),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic       m_s1 = 1'b0, m_s2 = 1'b0;
    logic [7:0] mk1 = 8'h00, mk2 = 8'h00;
    logic       m_filt = 1'b0;
    logic       hist[$];
    logic [7:0] q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs applied before it.
    task automatic model_step(input logic stb, input logic [7:0] key,
                              input logic a, input logic oc, input logic r);
        logic       samp;
        logic [7:0] ks;
        logic       all_diff;
        logic       cap;
        logic       set_ovr;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; mk1 = 8'h00; mk2 = 8'h00;
            m_filt = 1'b0; hist.delete(); q.delete();
            m_last = 8'h00; m_ovr = 1'b0;
        end else begin
            samp = m_s2;
            ks   = mk2;
            cap  = 1'b0;
            hist.push_back(samp);
            if (hist.size() > DC) void'(hist.pop_front());
            if (hist.size() == DC) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_filt) all_diff = 1'b0;
                if (all_diff) begin
                    m_filt = ~m_filt;
                    cap    = m_filt;
                end
            end
            if (a && q.size() > 0) void'(q.pop_front());
            set_ovr = 1'b0;
            if (cap) begin
                if (q.size() < CAP) begin
                    q.push_back(ks);
                    m_last = ks;
                end else begin
                    set_ovr = 1'b1;
                end
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
            m_s2 = m_s1; m_s1 = stb; mk2 = mk1; mk1 = key;
        end
    endtask

    // One clock cycle: drive, clock, update model, compare outputs.
    task automatic cyc(input logic stb, input logic [7:0] key,
                       input logic a, input logic oc, input logic r);
        key_stb_in = stb; key_in = key; ack = a; ovr_clr = oc; rst = r;
        @(posedge clk);
        model_step(stb, key, a, oc, r);
        #1;
        chk("en_inp", en_inp, (q.size() > 0));
        chk("overrun", overrun, m_ovr);
`ifdef KBD_FIFO_EN
        if (q.size() > 0) chk("keyboard", keyboard, q[0]);
`else
        chk("keyboard", keyboard, m_last);
`endif
    endtask

    task automatic hold(input int n, input logic stb, input logic [7:0] key);
        for (int i = 0; i < n; i++) cyc(stb, key, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int         run_left;
        logic       lvl;
        logic [7:0] k;

        // Reset state
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_en", en_inp, 1'b0);
        chk("rst_kb", keyboard, 8'h00);
        chk("rst_ovr", overrun, 1'b0);
        hold(2, 1'b0, 8'h00);

        // Clean strobe: valid after edge DC+2
        hold(5, 1'b1, 8'hA5);
        chk("clean_early", en_inp, 1'b0);
        hold(1, 1'b1, 8'hA5);
        chk("clean_en", en_inp, 1'b1);
        chk("clean_kb", keyboard, 8'hA5);
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("ack_en", en_inp, 1'b0);
        chk("ack_kb", keyboard, 8'hA5);
        hold(8, 1'b0, 8'hA5);

        // Bounce: 3 high, 1 low, 2 high, then low
        hold(3, 1'b1, 8'h77);
        hold(1, 1'b0, 8'h77);
        hold(2, 1'b1, 8'h77);
        hold(8, 1'b0, 8'h77);
        chk("bounce_en", en_inp, 1'b0);
        chk("bounce_ovr", overrun, 1'b0);

`ifndef KBD_FIFO_EN
        // Overrun: second capture without ack is dropped
        hold(6, 1'b1, 8'h11);
        hold(8, 1'b0, 8'h11);
        hold(6, 1'b1, 8'h22);
        chk("ovr_kb", keyboard, 8'h11);
        chk("ovr_set", overrun, 1'b1);
        hold(8, 1'b0, 8'h22);
        cyc(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr_clr", overrun, 1'b0);
        chk("ovr_hold_en", en_inp, 1'b1);

        // Ack on the capture edge of a new code
        hold(5, 1'b1, 8'h33);
        cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("sim_kb", keyboard, 8'h33);
        chk("sim_en", en_inp, 1'b1);
        chk("sim_ovr", overrun, 1'b0);
        hold(8, 1'b0, 8'h33);
        cyc(1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
`else
        // FIFO: five strobes without ack, then drain four
        for (int s = 1; s <= 5; s++) begin
            hold(6, 1'b1, 8'(s));
            hold(6, 1'b0, 8'(s));
        end
        chk("fifo_ovr", overrun, 1'b1);
        for (int s = 1; s <= 4; s++) begin
            chk("fifo_head", keyboard, 8'(s));
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("fifo_empty", en_inp, 1'b0);
`endif

        // Reset mid-debounce: strobe re-debounces from zero
        hold(2, 1'b1, 8'h5A);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_en", en_inp, 1'b0);
        chk("mid_rst_kb", keyboard, 8'h00);
        chk("mid_rst_ovr", overrun, 1'b0);
        hold(5, 1'b1, 8'h5A);
        chk("mid_rst_early", en_inp, 1'b0);
        hold(1, 1'b1, 8'h5A);
        chk("mid_rst_cap", en_inp, 1'b1);
        chk("mid_rst_kb2", keyboard, 8'h5A);
        hold(8, 1'b0, 8'h5A);
        cyc(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);

        // Randomized run against the model
        run_left = 0;
        lvl      = 1'b0;
        k        = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lvl      = ~lvl;
                run_left = $urandom_range(1, 8);
            end
            run_left--;
            if ($urandom_range(0, 3) == 0) k = 8'($urandom);
            cyc(lvl, k, ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 400) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_kbd_if
